// File: rtl/stream_demux_1ton_if.sv
// Stream bus for the 1:N demultiplexer: one producer-side beat channel
// and NUM_CH consumer-side channels packed into flat vectors.
interface stream_demux_1ton_if #(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 8,
    parameter int SEL_W  = $clog2(NUM_CH)
);
    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_W-1:0]        in_data;
    logic [SEL_W-1:0]         in_sel;
    logic                     in_bcast;
    logic [NUM_CH-1:0]        out_valid;
    logic [NUM_CH-1:0]        out_ready;
    logic [NUM_CH*DATA_W-1:0] out_data;

    // Demux side: consumes the input beat, drives the per-channel outputs.
    modport slave (
        input  in_valid, in_data, in_sel, in_bcast, out_ready,
        output in_ready, out_valid, out_data
    );

    // Environment side: producer plus all consumers.
    modport master (
        output in_valid, in_data, in_sel, in_bcast, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/stream_demux_1ton.sv
// Registered 1:N stream demultiplexer with one holding register per channel,
// broadcast mode and a saturating counter of beats sent to nonexistent channels.
module stream_demux_1ton #(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 8,
    parameter int SEL_W  = $clog2(NUM_CH),
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    stream_demux_1ton_if.slave     bus,
    output logic [CNT_W-1:0]       drop_cnt
);

    // Handshake: a beat moves when valid && ready on the same rising edge.
    // in_ready never looks at in_valid; out_valid never drops without a
    // handshake, and out_data is stable while out_valid && !out_ready.

    logic [NUM_CH-1:0]             valid_q;
    logic [NUM_CH-1:0]             valid_d;
    logic [NUM_CH-1:0][DATA_W-1:0] data_q;
    logic [NUM_CH-1:0][DATA_W-1:0] data_d;
    logic [CNT_W-1:0]              cnt_q;
    logic [CNT_W-1:0]              cnt_d;

    logic [NUM_CH-1:0]             chan_free;
    logic [NUM_CH-1:0]             sel_hit;
    logic [NUM_CH-1:0]             load;
    logic                          sel_legal;
    logic                          in_ready;
    logic                          accept;
    logic                          drop_inc;

    // A channel draining this cycle can be reloaded in the same cycle.
    always_comb begin
        chan_free = ~valid_q | bus.out_ready;
        sel_legal = ({1'b0, bus.in_sel} < (SEL_W + 1)'(NUM_CH));
        sel_hit   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel_hit[i] = (bus.in_sel == SEL_W'(i));
        end
    end

    always_comb begin
        in_ready = 1'b1;
        if (bus.in_bcast) begin
            in_ready = &chan_free;
        end else if (sel_legal) begin
            in_ready = |(sel_hit & chan_free);
        end
    end

    always_comb begin
        accept   = bus.in_valid & in_ready;
        drop_inc = accept & ~bus.in_bcast & ~sel_legal;
        load     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            load[i] = accept & (bus.in_bcast | sel_hit[i]);
        end
    end

    // Reload wins over drain; an undrained full channel keeps its beat.
    always_comb begin
        valid_d = '0;
        data_d  = data_q;
        for (int i = 0; i < NUM_CH; i++) begin
            valid_d[i] = load[i] | (valid_q[i] & ~bus.out_ready[i]);
            if (load[i]) begin
                data_d[i] = bus.in_data;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (drop_inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign drop_cnt      = cnt_q;

endmodule
